adder_tree_checker: RTL and testbench

Synthesizable self-checking monitor for the `adder_tree` output end. On a `start` pulse it snapshots the packed input bus fed to `adder_tree`. It computes the reference sum serially, one word per cycle, and captures the tree's `odata` exactly `DUT_LATENCY` cycles later. It then compares the two values and reports pass/fail plus running check and error counters. It sits beside `adder_tree` in benches and on-chip BIST wrappers, consuming the same `idata` and the tree's `odata`.

---
 rtl/adder_tree_checker.sv | 196 +++++++++++++++++++
 tb/tb_adder_tree_checker.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_tree_checker.sv
// ---------------------------------------------------------------------------
// adder_tree_checker
//
// Self-checking monitor that sits beside an adder_tree. A start request
// snapshots the packed input bus and builds a reference sum serially, one
// word per cycle. In parallel, the tree output is captured exactly
// DUT_LATENCY cycles after the snapshot. The two are then compared, and the
// result is published together with running check/error counters.
//
// Ports
//   clk        : single clock, rising edge
//   rst        : synchronous reset, active-high
//   start      : check request, honoured only while idle
//   idata      : packed input words fed to the tree (word i at i*IDATA_WIDTH)
//   odata      : tree output under check
//   busy       : a check is in progress
//   done       : one-cycle pulse, result outputs are valid
//   pass       : last result (1 = tree output matched), held
//   expected   : last reference sum, held
//   captured   : last captured tree output, held
//   check_cnt  : completed checks, saturating
//   err_cnt    : failed checks, saturating
// ---------------------------------------------------------------------------
module adder_tree_checker #(
    parameter int INPUTS_NUM  = 7,
    parameter int IDATA_WIDTH = 16,
    parameter int DUT_LATENCY = 3
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [INPUTS_NUM*IDATA_WIDTH-1:0]   idata,
    input  logic [IDATA_WIDTH+$clog2(INPUTS_NUM)-1:0] odata,
    output logic                                busy,
    output logic                                done,
    output logic                                pass,
    output logic [IDATA_WIDTH+$clog2(INPUTS_NUM)-1:0] expected,
    output logic [IDATA_WIDTH+$clog2(INPUTS_NUM)-1:0] captured,
    output logic [15:0]                         check_cnt,
    output logic [15:0]                         err_cnt
);

    localparam int ODATA_WIDTH = IDATA_WIDTH + $clog2(INPUTS_NUM);

    // Word index runs 0..INPUTS_NUM, latency counter 0..DUT_LATENCY
    localparam int WI_W = $clog2(INPUTS_NUM + 1);
    localparam int LC_W = $clog2(DUT_LATENCY + 1);

    localparam logic [WI_W-1:0] WI_END  = WI_W'(INPUTS_NUM);
    localparam logic [WI_W-1:0] WI_LAST = WI_W'(INPUTS_NUM - 1);
    localparam logic [WI_W-1:0] WI_ONE  = WI_W'(1);
    localparam logic [LC_W-1:0] LC_END  = LC_W'(DUT_LATENCY);
    localparam logic [LC_W-1:0] LC_CAP  = LC_W'(DUT_LATENCY - 1);
    localparam logic [LC_W-1:0] LC_ONE  = LC_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        CMP  = 2'd2
    } state_t;

    state_t                              r_state;
    state_t                              w_nextState;
    logic                                w_busy;
    logic                                w_accLast;
    logic                                w_capDone;
    logic                                w_match;
    logic [IDATA_WIDTH-1:0]              w_word;

    logic [INPUTS_NUM*IDATA_WIDTH-1:0]   r_snap;
    logic [ODATA_WIDTH-1:0]              r_acc;
    logic [WI_W-1:0]                     r_wi;
    logic [LC_W-1:0]                     r_lc;
    logic                                r_done;
    logic                                r_pass;
    logic [ODATA_WIDTH-1:0]              r_expected;
    logic [ODATA_WIDTH-1:0]              r_captured;
    logic [15:0]                         r_checkCnt;
    logic [15:0]                         r_errCnt;

    // The cycle that adds the last word and the cycle that captures odata
    // may differ; CMP is entered only once both have happened.
    assign w_accLast = (r_wi >= WI_LAST);
    assign w_capDone = (r_lc >= LC_CAP);
    assign w_match   = (r_acc == r_captured);

    // Select the snapshot word pointed to by the serial word index
    always_comb begin
        w_word = '0;
        for (int i = 0; i < INPUTS_NUM; i++) begin
            if (r_wi == WI_W'(i)) begin
                w_word = r_snap[i*IDATA_WIDTH +: IDATA_WIDTH];
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic; busy covers both RUN and CMP so that start is
    // ignored for the whole check
    always_comb begin
        w_nextState = r_state;
        w_busy      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_nextState = RUN;
                end
            end
            RUN: begin
                w_busy = 1'b1;
                if (w_accLast && w_capDone) begin
                    w_nextState = CMP;
                end
            end
            CMP: begin
                w_busy      = 1'b1;
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Datapath: snapshot, serial accumulation, odata capture, and the
    // comparison results. done is registered from CMP so that it lands in
    // the cycle after CMP together with the updated results.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_snap     <= '0;
            r_acc      <= '0;
            r_wi       <= '0;
            r_lc       <= '0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_expected <= '0;
            r_captured <= '0;
            r_checkCnt <= '0;
            r_errCnt   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_snap <= idata;
                        r_acc  <= '0;
                        r_wi   <= '0;
                        r_lc   <= '0;
                    end
                end
                RUN: begin
                    if (r_wi < WI_END) begin
                        r_acc <= r_acc + ODATA_WIDTH'(w_word);
                        r_wi  <= r_wi + WI_ONE;
                    end
                    if (r_lc < LC_END) begin
                        r_lc <= r_lc + LC_ONE;
                    end
                    if (r_lc == LC_CAP) begin
                        r_captured <= odata;
                    end
                end
                CMP: begin
                    r_done     <= 1'b1;
                    r_pass     <= w_match;
                    r_expected <= r_acc;
                    if (r_checkCnt != 16'hFFFF) begin
                        r_checkCnt <= r_checkCnt + 16'd1;
                    end
                    if (!w_match && (r_errCnt != 16'hFFFF)) begin
                        r_errCnt <= r_errCnt + 16'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy      = w_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign expected  = r_expected;
    assign captured  = r_captured;
    assign check_cnt = r_checkCnt;
    assign err_cnt   = r_errCnt;

endmodule

// File: tb/tb_adder_tree_checker.sv
// ---------------------------------------------------------------------------
// tb_adder_tree_checker
//
// Directed bench for adder_tree_checker with the default parameters
// (7 words of 16 bits, latency 3, 19-bit sum). Each step drives a check and
// compares busy/done timing, the held results and the counters against
// hand-computed values.
// ---------------------------------------------------------------------------
module tb_adder_tree_checker;

    localparam int N  = 7;
    localparam int W  = 16;
    localparam int OW = 19;

    logic              clk;
    logic              rst;
    logic              start;
    logic [N*W-1:0]    idata;
    logic [OW-1:0]     odata;
    logic              busy;
    logic              done;
    logic              pass;
    logic [OW-1:0]     expected;
    logic [OW-1:0]     captured;
    logic [15:0]       check_cnt;
    logic [15:0]       err_cnt;

    int checks   = 0;
    int failures = 0;

    logic [12:0] busyBits;
    logic [12:0] doneBits;
    logic [27:0] b2bDone;
    logic        doneSeen;

    adder_tree_checker #(
        .INPUTS_NUM (N),
        .IDATA_WIDTH(W),
        .DUT_LATENCY(3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .idata    (idata),
        .odata    (odata),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .expected (expected),
        .captured (captured),
        .check_cnt(check_cnt),
        .err_cnt  (err_cnt)
    );

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Replicate one word value across all input words
    function automatic logic [N*W-1:0] allWords(input logic [W-1:0] v);
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) begin
            r[i*W +: W] = v;
        end
        return r;
    endfunction

    // Words 1..7 in ascending order
    function automatic logic [N*W-1:0] rampWords();
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) begin
            r[i*W +: W] = W'(i + 1);
        end
        return r;
    endfunction

    // One comparison point
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] exp);
        checks++;
        assert (observed === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, exp);
        end
    endtask

    // Runs one check starting at the next negedge (cycle 0). Inputs are
    // changed at negedges; outputs are read at the same negedge before the
    // change, so bit c of the vectors holds the cycle-c value. odCycle<0
    // holds odVal throughout, otherwise odVal appears only in that cycle.
    task automatic applyStimulus(input logic [N*W-1:0] data, input logic [OW-1:0] odVal,
                                 input int odCycle, input int reStartCycle,
                                 input int zeroCycle,
                                 output logic [12:0] bBits, output logic [12:0] dBits);
        bBits = '0;
        dBits = '0;
        @(negedge clk);
        start = 1'b1;
        idata = data;
        odata = (odCycle < 0 || odCycle == 0) ? odVal : '0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            bBits[c] = busy;
            dBits[c] = done;
            start = (c == reStartCycle);
            if (zeroCycle >= 0 && c >= zeroCycle) begin
                idata = '0;
            end
            odata = (odCycle < 0 || odCycle == c) ? odVal : '0;
        end
        start = 1'b0;
    endtask

    // start held high for 27 cycles; records done per cycle
    task automatic runBackToBack(input logic [N*W-1:0] data, input logic [OW-1:0] odVal,
                                 output logic [27:0] dBits);
        dBits = '0;
        @(negedge clk);
        start = 1'b1;
        idata = data;
        odata = odVal;
        for (int c = 1; c <= 27; c++) begin
            @(negedge clk);
            dBits[c] = done;
            if (c == 27) begin
                start = 1'b0;
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        idata = '0;
        odata = '0;
        repeat (2) @(negedge clk);

        // Reset state
        checkOutput("rst_busy",  32'(busy),      32'd0);
        checkOutput("rst_done",  32'(done),      32'd0);
        checkOutput("rst_pass",  32'(pass),      32'd0);
        checkOutput("rst_exp",   32'(expected),  32'd0);
        checkOutput("rst_cap",   32'(captured),  32'd0);
        checkOutput("rst_chk",   32'(check_cnt), 32'd0);
        checkOutput("rst_err",   32'(err_cnt),   32'd0);
        rst = 1'b0;

        // All ones, odata held at 7
        applyStimulus(allWords(16'd1), 19'd7, -1, -1, -1, busyBits, doneBits);
        checkOutput("t1_busy", 32'(busyBits), 32'h1FE);
        checkOutput("t1_done", 32'(doneBits), 32'h200);
        checkOutput("t1_pass", 32'(pass), 32'd1);
        checkOutput("t1_exp",  32'(expected), 32'd7);
        checkOutput("t1_cap",  32'(captured), 32'd7);
        checkOutput("t1_chk",  32'(check_cnt), 32'd1);
        checkOutput("t1_err",  32'(err_cnt), 32'd0);

        // All 0xFFFF: full-scale sum fits in 19 bits
        applyStimulus(allWords(16'hFFFF), 19'h6FFF9, -1, -1, -1, busyBits, doneBits);
        checkOutput("t2_done", 32'(doneBits), 32'h200);
        checkOutput("t2_pass", 32'(pass), 32'd1);
        checkOutput("t2_exp",  32'(expected), 32'h6FFF9);
        checkOutput("t2_chk",  32'(check_cnt), 32'd2);

        // Capture alignment: 7 only in cycle 3 matches
        applyStimulus(allWords(16'd1), 19'd7, 3, -1, -1, busyBits, doneBits);
        checkOutput("t3_pass", 32'(pass), 32'd1);
        checkOutput("t3_cap",  32'(captured), 32'd7);
        checkOutput("t3_err",  32'(err_cnt), 32'd0);

        // 7 only in cycle 2: too early
        applyStimulus(allWords(16'd1), 19'd7, 2, -1, -1, busyBits, doneBits);
        checkOutput("t4_pass", 32'(pass), 32'd0);
        checkOutput("t4_cap",  32'(captured), 32'd0);
        checkOutput("t4_exp",  32'(expected), 32'd7);
        checkOutput("t4_err",  32'(err_cnt), 32'd1);

        // 7 only in cycle 4: too late
        applyStimulus(allWords(16'd1), 19'd7, 4, -1, -1, busyBits, doneBits);
        checkOutput("t5_pass", 32'(pass), 32'd0);
        checkOutput("t5_cap",  32'(captured), 32'd0);
        checkOutput("t5_err",  32'(err_cnt), 32'd2);
        checkOutput("t5_chk",  32'(check_cnt), 32'd5);

        // start re-pulsed in cycle 4, idata zeroed from cycle 1
        applyStimulus(allWords(16'd1), 19'd7, -1, 4, 1, busyBits, doneBits);
        checkOutput("t6_busy", 32'(busyBits), 32'h1FE);
        checkOutput("t6_done", 32'(doneBits), 32'h200);
        checkOutput("t6_exp",  32'(expected), 32'd7);
        checkOutput("t6_pass", 32'(pass), 32'd1);
        checkOutput("t6_chk",  32'(check_cnt), 32'd6);

        // Reset in cycle 5 aborts the check
        doneSeen = 1'b0;
        @(negedge clk);
        start = 1'b1;
        idata = allWords(16'd1);
        odata = 19'd7;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (c >= 5) begin
                doneSeen = doneSeen | done;
            end
            if (c == 6) begin
                checkOutput("t7_busy_c6", 32'(busy), 32'd0);
            end
            start = 1'b0;
            rst   = (c == 5);
        end
        checkOutput("t7_nodone", 32'(doneSeen), 32'd0);
        checkOutput("t7_chk",    32'(check_cnt), 32'd0);
        checkOutput("t7_err",    32'(err_cnt), 32'd0);
        checkOutput("t7_exp",    32'(expected), 32'd0);
        checkOutput("t7_cap",    32'(captured), 32'd0);
        checkOutput("t7_pass",   32'(pass), 32'd0);

        // rst and start together: start dropped
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        checkOutput("t8_busy", 32'(busy), 32'd0);
        @(negedge clk);
        checkOutput("t8_busy2", 32'(busy), 32'd0);

        // Normal check after abort, ramp data 1..7 sums to 28
        applyStimulus(rampWords(), 19'd28, -1, -1, -1, busyBits, doneBits);
        checkOutput("t9_done", 32'(doneBits), 32'h200);
        checkOutput("t9_pass", 32'(pass), 32'd1);
        checkOutput("t9_exp",  32'(expected), 32'd28);
        checkOutput("t9_chk",  32'(check_cnt), 32'd1);

        // Back-to-back with a mismatching odata: done every 9 cycles
        runBackToBack(allWords(16'd1), 19'd5, b2bDone);
        checkOutput("t10_done", 32'(b2bDone), 32'h8040200);
        checkOutput("t10_pass", 32'(pass), 32'd0);
        checkOutput("t10_cap",  32'(captured), 32'd5);
        checkOutput("t10_chk",  32'(check_cnt), 32'd4);
        checkOutput("t10_err",  32'(err_cnt), 32'd3);

        // Saturation: preload both counters just below full scale
        @(negedge clk);
        force dut.r_checkCnt = 16'hFFFE;
        force dut.r_errCnt   = 16'hFFFE;
        @(negedge clk);
        release dut.r_checkCnt;
        release dut.r_errCnt;
        runBackToBack(allWords(16'd1), 19'd5, b2bDone);
        checkOutput("t11_done", 32'(b2bDone), 32'h8040200);
        checkOutput("t11_chk",  32'(check_cnt), 32'hFFFF);
        checkOutput("t11_err",  32'(err_cnt), 32'hFFFF);
        repeat (12) @(negedge clk);
        checkOutput("t11_idle", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
